// File: rtl/mips_divider.sv
// mips_divider
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// It holds the pipeline through div_stall while it iterates, producing one
// quotient bit per cycle. It then presents {remainder, quotient} for one cycle
// on result/result_valid, to be written into HI/LO.
//
// Ports
//   clk          pipeline clock, rising edge
//   resetn       asynchronous active-low reset
//   div_start    execute-stage instruction is DIV/DIVU (held while stalled)
//   div_signed   1 = DIV (two's complement), 0 = DIVU
//   opa, opb     dividend / divisor (forwarded rs / rt)
//   annul        flush; aborts any division in flight, overrides div_start
//   div_stall    stall request to the hazard unit (combinational)
//   result_valid one-cycle strobe, result valid this cycle
//   result       {remainder, quotient} -> {HI, LO}
//
// state | meaning
// IDLE  | waiting for div_start; operands latched on acceptance
// BUSY  | WIDTH iterations, one quotient bit per cycle
// DONE  | result presented for one cycle, then back to IDLE

module mips_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic               div_stall,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    logic [CW-1:0]    iterCnt;
    logic [WIDTH:0]   remReg;       // partial remainder, one bit wider than the divisor
    logic [WIDTH-1:0] dvdQuotReg;   // dividend shifts out the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] rawOpa;
    logic             qNeg;
    logic             rNeg;
    logic             dZero;

    logic [WIDTH+1:0] remShift;
    logic [WIDTH:0]   trialDiff;
    logic             noBorrow;
    logic [WIDTH:0]   remNext;
    logic [WIDTH-1:0] quotNext;
    logic [WIDTH-1:0] quotFinal;
    logic [WIDTH-1:0] remFinal;
    logic             lastIter;

    always_comb begin
        remShift  = {remReg, dvdQuotReg[WIDTH-1]};
        noBorrow  = (remShift >= {2'b00, divisorReg});
        trialDiff = remShift[WIDTH:0] - {1'b0, divisorReg};
        remNext   = noBorrow ? trialDiff : remShift[WIDTH:0];
        quotNext  = {dvdQuotReg[WIDTH-2:0], noBorrow};
        lastIter  = (iterCnt == CW'(WIDTH - 1));

        // Divide by zero bypasses sign fixup entirely: all-ones quotient, raw dividend as remainder.
        if (dZero) begin
            quotFinal = '1;
            remFinal  = rawOpa;
        end else begin
            quotFinal = qNeg ? -quotNext : quotNext;
            remFinal  = rNeg ? -remNext[WIDTH-1:0] : remNext[WIDTH-1:0];
        end
    end

    // Stall in the same cycle the divide enters E; an annul releases the pipeline immediately.
    assign div_stall    = resetn & ~annul & (((state == IDLE) & div_start) | (state == BUSY));
    assign result_valid = (state == DONE) & ~annul;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            iterCnt    <= '0;
            remReg     <= '0;
            dvdQuotReg <= '0;
            divisorReg <= '0;
            rawOpa     <= '0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            dZero      <= 1'b0;
            result     <= '0;
        end else if (annul) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        // Magnitudes are unsigned WIDTH-bit, so |0x80000000| stays representable.
                        dvdQuotReg <= (div_signed & opa[WIDTH-1]) ? -opa : opa;
                        divisorReg <= (div_signed & opb[WIDTH-1]) ? -opb : opb;
                        qNeg       <= div_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        rNeg       <= div_signed & opa[WIDTH-1];
                        dZero      <= (opb == '0);
                        rawOpa     <= opa;
                        remReg     <= '0;
                        iterCnt    <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    remReg     <= remNext;
                    dvdQuotReg <= quotNext;
                    iterCnt    <= iterCnt + CW'(1);
                    if (lastIter) begin
                        // Final value lands in result so it is already valid during DONE.
                        result <= {remFinal, quotFinal};
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_divider.sv
// tb_mips_divider
// Directed test of mips_divider with a reference model based on plain integer
// division. A per-cycle compare process checks div_stall/result_valid/result
// against a timeline model; directed vectors add hand-computed literal results,
// latency and stall-length expectations.

module tb_mips_divider;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        div_stall;
    logic        result_valid;
    logic [63:0] result;

    int nVec = 0;
    int nErr = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mips_divider #(.WIDTH(32)) dut (
        .clk(clk),
        .resetn(resetn),
        .div_start(div_start),
        .div_signed(div_signed),
        .opa(opa),
        .opb(opb),
        .annul(annul),
        .div_stall(div_stall),
        .result_valid(result_valid),
        .result(result)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics with wide integer arithmetic.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Timeline model: age is -1 when no divide is in flight, else cycles since acceptance.
    int          age = -1;
    logic [63:0] expRes = '0;
    logic [63:0] lastRes = '0;
    bit          holdKnown = 1'b1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            age       <= -1;
            lastRes   <= '0;
            holdKnown <= 1'b1;
        end else if (age < 0) begin
            if (div_start && !annul) begin
                expRes <= refDiv(div_signed, opa, opb);
                age    <= 1;
            end
        end else if (annul) begin
            if (age == 33) holdKnown <= 1'b0;
            age <= -1;
        end else if (age == 33) begin
            lastRes   <= expRes;
            holdKnown <= 1'b1;
            age       <= -1;
        end else begin
            age <= age + 1;
        end
    end

    always @(negedge clk) begin
        logic es, ev;
        if (!resetn) begin
            chk("rst_stall", {63'b0, div_stall}, 64'd0);
            chk("rst_valid", {63'b0, result_valid}, 64'd0);
            chk("rst_result", result, 64'd0);
        end else begin
            if (age < 0)        es = div_start & ~annul;
            else if (age <= 32) es = ~annul;
            else                es = 1'b0;
            ev = (age == 33) & ~annul;
            chk("div_stall", {63'b0, div_stall}, {63'b0, es});
            chk("result_valid", {63'b0, result_valid}, {63'b0, ev});
            if (ev) chk("result_model", result, expRes);
            else if (age < 0 && holdKnown) chk("result_hold", result, lastRes);
        end
    end

    // Starts a divide in the current cycle (caller is between edges, before the accepting edge).
    task automatic runDiv(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expLit, input bit keepStart, input bit dropMid,
                          output int doneCyc);
        int startCyc;
        int stalls;
        bit got;
        div_start  = 1'b1;
        div_signed = sgn;
        opa        = a;
        opb        = b;
        startCyc   = cyc;
        stalls     = 0;
        got        = 1'b0;
        doneCyc    = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (div_stall) stalls++;
            if (result_valid) begin
                got     = 1'b1;
                doneCyc = cyc;
                chk(nm, result, expLit);
                chk({nm, "_latency"}, 64'(cyc - startCyc), 64'd33);
            end
            if (i == 3) begin
                opa = 32'hDEAD_BEEF;
                opb = 32'h0;
            end
            if (dropMid && i == 5) div_start = 1'b0;
        end
        if (!got) begin
            nVec++;
            nErr++;
            $display("FAIL %s_timeout: result_valid not seen within 60 cycles", nm);
        end
        chk({nm, "_stallcycles"}, 64'(stalls), 64'd33);
        if (!keepStart) begin
            @(posedge clk);
            #1;
            div_start = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int d1, d2, vcount;

        #1 resetn = 1'b0;
        #11 resetn = 1'b1;

        chk("model_pin_divu", refDiv(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
        chk("model_pin_div", refDiv(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_pin_ovf", refDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});

        repeat (2) @(posedge clk);
        #1;
        runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 0, 0, d1);
        @(posedge clk); #1;
        runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0, d1);
        @(posedge clk); #1;
        runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 0, 1, d1);
        @(posedge clk); #1;
        runDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 0, 0, d1);
        @(posedge clk); #1;
        runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF}, 0, 0, d1);
        @(posedge clk); #1;
        runDiv("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0, 0, d1);
        @(posedge clk); #1;
        runDiv("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0, 0, d1);
        @(posedge clk); #1;
        runDiv("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 0, 0, d1);
        @(posedge clk); #1;
        runDiv("divu_big_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0000_0000, 32'hFFFF_FFFF}, 0, 0, d1);

        // Annul in BUSY cycle 10
        @(posedge clk); #1;
        div_start = 1'b1; div_signed = 1'b0; opa = 32'd1000; opb = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        chk("annul_busy_stall", {63'b0, div_stall}, 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; div_start = 1'b0;
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) vcount++;
        end
        chk("annul_no_valid", 64'(vcount), 64'd0);
        @(posedge clk); #1;
        runDiv("divu_ffffffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 0, 0, d1);

        // Annul landing on the DONE cycle
        @(posedge clk); #1;
        div_start = 1'b1; div_signed = 1'b0; opa = 32'd50; opb = 32'd5;
        repeat (33) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        chk("annul_done_valid", {63'b0, result_valid}, 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; div_start = 1'b0;
        @(posedge clk); #1;
        runDiv("divu_50_5", 1'b0, 32'd50, 32'd5, {32'h0, 32'h0000_000A}, 0, 0, d1);

        // Asynchronous reset mid-BUSY
        @(posedge clk); #1;
        div_start = 1'b1; div_signed = 1'b0; opa = 32'd100; opb = 32'd7;
        repeat (15) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("rst_async_stall", {63'b0, div_stall}, 64'd0);
        chk("rst_async_valid", {63'b0, result_valid}, 64'd0);
        chk("rst_async_result", result, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        runDiv("post_rst_100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 0, 0, d1);

        // Back-to-back divides with div_start held across DONE
        @(posedge clk); #1;
        runDiv("b2b_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 1, 0, d1);
        @(posedge clk); #1;
        runDiv("b2b_10_4", 1'b0, 32'd10, 32'd4, {32'h2, 32'h2}, 0, 0, d2);
        chk("b2b_spacing", 64'(d2 - d1), 64'd34);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
